ber_checker_mc: RTL

Multi-channel BER checker that replaces the fixed per-lane BER counters in the PRBS/FIR/downsampler link. Each lane makes a hard decision on the downsampled sample and searches for the reference-PRBS delay that aligns with the received stream. It then locks, keeps saturating sample and error counts, and drops lock when errors exceed a threshold. Counters of one lane at a time are read through a snapshot port.

---
 rtl/ber_checker_pkg.sv | 10 +
 rtl/ber_lane.sv | 120 ++++++++++++
 rtl/ber_checker_mc.sv | 84 ++++++++
 3 files changed

// File: rtl/ber_checker_pkg.sv
// ber_checker_pkg: lane FSM states, window length and saturating counter helper shared by the BER checker
package ber_checker_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_t;
  function automatic int win_len(input int nb_win);
    return (1 << nb_win) - 1;
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v == max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/ber_lane.sv
// ber_lane: one lane's reference delay line, search/lock FSM and saturating sample/error counters
// BER_CHECKER_INVERT_DETECT_EN: an all-error search window also locks, with the decided bit inverted
module ber_lane
  import ber_checker_pkg::*;
#(
  parameter int NB_DELAY = 9,
  parameter int NB_WIN   = 9,
  parameter int LOL_THR  = 16,
  parameter int NB_CNT   = 64
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_msb,
  input  logic                i_ref_bit,
  input  logic                i_valid,
  input  logic                i_enb,
  input  logic                i_clr,
  output logic                o_bit,
  output logic                o_lock,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_smp_cnt,
  output logic [NB_CNT-1:0]   o_err_cnt
);
  localparam int NTAP = 2 ** NB_DELAY;
  localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(win_len(NB_WIN) - 1);
  localparam logic [63:0] CNT_MAX = 64'({NB_CNT{1'b1}});
  state_t state_q, state_d;
  logic [NTAP-2:0] line_q, line_d;
  logic [NTAP-1:0] taps;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_WIN-1:0] win_q, win_d, ew_q, ew_d, ew_nxt;
  logic [NB_CNT-1:0] smp_q, smp_d, err_q, err_d;
  logic lock_q, lock_d, inv_q, inv_d, bit_q, bit_d;
  logic step, dec, mis, win_end;
  // tap 0 is the current reference bit, tap k the bit from k symbols ago
  assign taps    = {line_q, i_ref_bit};
  assign step    = i_valid & i_enb;
  assign dec     = i_msb ^ inv_q;
  assign mis     = dec ^ taps[delay_q];
  assign win_end = win_q == WIN_LAST;
  assign ew_nxt  = ew_q + NB_WIN'(mis);
  // next-state: delay search, lock supervision, counters; clear overrides counting
  always_comb begin
    state_d = state_q;
    line_d  = step ? taps[NTAP-2:0] : line_q;
    delay_d = delay_q;
    win_d   = win_q;
    ew_d    = ew_q;
    lock_d  = lock_q;
    inv_d   = inv_q;
    bit_d   = i_valid ? dec : bit_q;
    smp_d   = smp_q;
    err_d   = err_q;
    if (step && state_q == IDLE) state_d = SEARCH;
    if (step && state_q != IDLE) begin
      win_d = win_end ? '0 : win_q + 1'b1;
      ew_d  = win_end ? '0 : ew_nxt;
    end
    if (step && state_q == LOCK) begin
      smp_d = NB_CNT'(sat_inc(64'(smp_q), CNT_MAX));
      err_d = mis ? NB_CNT'(sat_inc(64'(err_q), CNT_MAX)) : err_q;
    end
    if (step && win_end && state_q == SEARCH) begin
      if (ew_nxt == '0) begin
        state_d = LOCK;
        lock_d  = 1'b1;
      end
`ifdef BER_CHECKER_INVERT_DETECT_EN
      else if (ew_nxt == NB_WIN'(win_len(NB_WIN))) begin
        state_d = LOCK;
        lock_d  = 1'b1;
        inv_d   = 1'b1;
      end
`endif
      else delay_d = delay_q + 1'b1;
    end
    if (step && win_end && state_q == LOCK && ew_nxt > NB_WIN'(LOL_THR)) begin
      state_d = SEARCH;
      lock_d  = 1'b0;
      inv_d   = 1'b0;
      delay_d = delay_q + 1'b1;
    end
    if (!(state_q inside {IDLE, SEARCH, LOCK})) state_d = IDLE;
    if (i_clr) begin
      smp_d = '0;
      err_d = '0;
    end
  end
  // lane FSM with its registered lock/bit outputs, delay line and counters
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      delay_q <= '0;
      win_q   <= '0;
      ew_q    <= '0;
      lock_q  <= 1'b0;
      inv_q   <= 1'b0;
      bit_q   <= 1'b0;
      smp_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      delay_q <= delay_d;
      win_q   <= win_d;
      ew_q    <= ew_d;
      lock_q  <= lock_d;
      inv_q   <= inv_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      err_q   <= err_d;
    end
  end
  assign o_bit     = bit_q;
  assign o_lock    = lock_q;
  assign o_delay   = delay_q;
  assign o_smp_cnt = smp_q;
  assign o_err_cnt = err_q;
endmodule

// File: rtl/ber_checker_mc.sv
// ber_checker_mc: multi-lane PRBS BER checker with per-lane delay search, lock and a lane snapshot port
// BER_CHECKER_INVERT_DETECT_EN: every lane may also lock on an inverted stream
module ber_checker_mc
  import ber_checker_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int NB_DATA  = 12,
  parameter int NB_DELAY = 9,
  parameter int NB_WIN   = 9,
  parameter int LOL_THR  = 16,
  parameter int NB_CNT   = 64,
  parameter int NB_SEL   = 1
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic [N_CH*NB_DATA-1:0] i_data,
  input  logic [N_CH-1:0]         i_ref_bit,
  input  logic                    i_valid,
  input  logic                    i_enb,
  input  logic                    i_clr,
  input  logic                    i_latch,
  input  logic [NB_SEL-1:0]       i_ch_sel,
  output logic [N_CH-1:0]         o_bit,
  output logic [N_CH-1:0]         o_lock,
  output logic [NB_DELAY-1:0]     o_delay,
  output logic [NB_CNT-1:0]       o_smp_cnt,
  output logic [NB_CNT-1:0]       o_err_cnt
);
  logic [NB_DELAY-1:0] dly [N_CH];
  logic [NB_CNT-1:0] smp [N_CH];
  logic [NB_CNT-1:0] err [N_CH];
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_CNT-1:0] smp_q, smp_d, err_q, err_d;
  logic unused_lsbs;
  assign unused_lsbs = ^i_data;
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    ber_lane #(
      .NB_DELAY(NB_DELAY),
      .NB_WIN  (NB_WIN),
      .LOL_THR (LOL_THR),
      .NB_CNT  (NB_CNT)
    ) u_lane (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_msb    (i_data[k*NB_DATA+NB_DATA-1]),
      .i_ref_bit(i_ref_bit[k]),
      .i_valid  (i_valid),
      .i_enb    (i_enb),
      .i_clr    (i_clr),
      .o_bit    (o_bit[k]),
      .o_lock   (o_lock[k]),
      .o_delay  (dly[k]),
      .o_smp_cnt(smp[k]),
      .o_err_cnt(err[k])
    );
  end
  // lane select for the live delay and the snapshot; unknown lanes read as zero
  always_comb begin
    delay_d = '0;
    smp_d   = i_latch ? '0 : smp_q;
    err_d   = i_latch ? '0 : err_q;
    for (int i = 0; i < N_CH; i++)
      if (i_ch_sel == NB_SEL'(i)) begin
        delay_d = dly[i];
        smp_d   = i_latch ? smp[i] : smp_q;
        err_d   = i_latch ? err[i] : err_q;
      end
  end
  // registered delay view and snapshot; lane counters are still pre-clear in a clear cycle
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      delay_q <= '0;
      smp_q   <= '0;
      err_q   <= '0;
    end else begin
      delay_q <= delay_d;
      smp_q   <= smp_d;
      err_q   <= err_d;
    end
  end
  assign o_delay   = delay_q;
  assign o_smp_cnt = smp_q;
  assign o_err_cnt = err_q;
endmodule
